dsc_mul_ctrl: RTL
=================

# dsc_mul_ctrl

Sequencing controller for the 3-input deterministic stochastic multiplier `dsc_mul`. It accepts operand triples over a valid/ready handshake and launches each multiply by pulsing the multiplier's reset and holding its enable. It waits for the multiplier's `ov` completion flag, then returns the product and the measured cycle count over a second valid/ready handshake. It sits between an operand source (DMA, test sequencer) and one `dsc_mul` instance, and it owns that instance's `rst`/`en` pins exclusively.

## Interface
Parameters:
- `NUM_BITS`, 6, width of each operand.
- `NUM_INPUTS`, 3, operand count; product width is `NUM_INPUTS*NUM_BITS`.
- `CLR_CYC`, 1, number of cycles `mul_rst` is held high before each run (≥1).
- `CYC_W`, 20, width of the cycle counter.
- `TIMEOUT_CYC`, 2**(NUM_INPUTS*NUM_BITS)+16, number of RUN cycles after which a run is aborted (must be < 2**CYC_W).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand triple valid.
- `in_ready`  out  1  controller can accept a triple.
- `in_a`, `in_b`, `in_c`  in  NUM_BITS each  operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_z`  out  NUM_INPUTS*NUM_BITS  product.
- `out_cycles`  out  CYC_W  RUN cycles consumed by this operation.
- `out_timeout`  out  1  result was produced by timeout, not by `ov`.
- `out_mismatch`  out  1  product differs from the exact product (see Configuration).
- `busy`  out  1  state ≠ IDLE.
- `mul_rst`  out  1  to `dsc_mul.rst` (active high).
- `mul_en`  out  1  to `dsc_mul.en`.
- `mul_a`, `mul_b`, `mul_c`  out  NUM_BITS each  latched operands to the multiplier.
- `mul_z`  in  NUM_INPUTS*NUM_BITS  from `dsc_mul.z`.
- `mul_ov`  in  1  from `dsc_mul.ov`.

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: `in_ready`=1, `mul_rst`=1, `mul_en`=0. On `in_valid & in_ready`:
  - latch `in_a/b/c` into `mul_a/b/c`;
  - clear the clear-counter and the cycle counter;
  - go to CLEAR.
- CLEAR: `mul_rst`=1, `mul_en`=0 for exactly `CLR_CYC` cycles, then go to RUN.
- RUN: `mul_rst`=0, `mul_en`=1. The cycle counter increments every RUN cycle.
  - If `mul_ov` is sampled high: capture `mul_z` into `out_z`, capture the counter value including the current cycle into `out_cycles`, set `out_timeout`=0, go to DONE.
  - Otherwise, if the counter reaches `TIMEOUT_CYC`: capture the current `mul_z`, set `out_cycles`=TIMEOUT_CYC and `out_timeout`=1, go to DONE.
  - If `mul_ov` and the timeout condition occur in the same cycle, `ov` wins and `out_timeout`=0.
- DONE: `out_valid`=1, `mul_en`=0, `mul_rst`=0 (multiplier state is held for observation).
  - `out_z`, `out_cycles`, `out_timeout` and `out_mismatch` stay stable until `out_valid & out_ready`; then go to IDLE.
  - A new triple is accepted only in IDLE, so there is no accept in the handoff cycle.
- `in_valid` is ignored outside IDLE. Operands change on `mul_a/b/c` only at accept.

## Timing
- Reset values (async, on `rst_n`=0):
  - state IDLE;
  - `in_ready`=1, `out_valid`=0, `busy`=0;
  - `mul_rst`=1, `mul_en`=0;
  - `mul_a/b/c`=0, `out_z`=0, `out_cycles`=0, `out_timeout`=0, `out_mismatch`=0.
- Reset asserted mid-operation aborts immediately. The multiplier sees `mul_rst`=1 and `mul_en`=0 asynchronously, and no result is emitted.
- Accept edge → first `mul_en`=1 cycle: `CLR_CYC`+1 cycles.
- `ov` sampled in the first RUN cycle → `out_cycles`=1. `out_valid` rises on the edge after the `ov` sample (1-cycle latency).
- Minimum accept-to-accept period: `CLR_CYC` + run length + 2 cycles, with `out_ready` held high.
- `in_ready` and `out_valid` are decoded from registered state only (no combinational path from the inputs).

## Configuration
- `DSC_MUL_CTRL_CHECK_EN` defined:
  - at accept, register the exact product `in_a*in_b*in_c`, computed at full `NUM_INPUTS*NUM_BITS` width;
  - in DONE, `out_mismatch` = (captured `out_z` ≠ exact product), held with the result;
  - a timeout result always sets `out_mismatch`=1.
- `DSC_MUL_CTRL_CHECK_EN` undefined: no multiplier or exact-product register is built, and `out_mismatch` is tied to 0.

## Test plan
- a=b=c=15 with the real `dsc_mul` and `out_ready`=1 → one `out_valid` pulse with `out_z`=3375, `out_timeout`=0, `out_mismatch`=0, `out_cycles`>0.
- a=63, b=63, c=63 then a=0, b=5, c=7 back-to-back → results in order: 250047 then 0. `in_ready`=0 from accept until the first result handoff.
- Stub multiplier asserting `ov` in the first RUN cycle, `CLR_CYC`=3 → `mul_rst` high for exactly 3 cycles after accept, then `out_cycles`=1. `out_ready` held low 5 cycles → `out_valid`=1 and all result fields stable for those 5 cycles.
- Stub never asserts `ov`, `TIMEOUT_CYC`=100 → result after 100 RUN cycles with `out_timeout`=1, `out_cycles`=100, and `out_mismatch`=1 when CHECK_EN is defined.
- Stub returns `z`=1 for a=b=c=2 → `out_z`=1. `out_mismatch`=1 with CHECK_EN defined, 0 without.
- `rst_n` pulsed low in the 10th RUN cycle → `mul_rst`=1, `mul_en`=0, `busy`=0, `out_valid`=0 immediately. The next triple a=b=c=1 completes with `out_z`=1.

Source files
------------

// File: rtl/dsc_mul_ctrl.sv
// dsc_mul_ctrl: sequencing controller for one 3-input deterministic stochastic
// multiplier (dsc_mul). It accepts an operand triple, clears the multiplier,
// runs it until its ov flag rises or a timeout expires, and then hands back the
// product together with the number of run cycles used.
//
// Optional build macro: DSC_MUL_CTRL_CHECK_EN
//   defined   - registers the exact product at accept and flags out_mismatch
//               when the returned product differs from it (timeouts always flag)
//   undefined - no checker hardware is built, and out_mismatch is tied low
module dsc_mul_ctrl #(
  parameter int NUM_BITS    = 6,
  parameter int NUM_INPUTS  = 3,
  parameter int CLR_CYC     = 1,
  parameter int CYC_W       = 20,
  parameter int TIMEOUT_CYC = 2**(NUM_INPUTS*NUM_BITS) + 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // operand side
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_BITS-1:0]            in_a,
  input  logic [NUM_BITS-1:0]            in_b,
  input  logic [NUM_BITS-1:0]            in_c,
  // result side
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_INPUTS*NUM_BITS-1:0] out_z,
  output logic [CYC_W-1:0]               out_cycles,
  output logic                           out_timeout,
  output logic                           out_mismatch,
  output logic                           busy,
  // multiplier side
  output logic                           mul_rst,
  output logic                           mul_en,
  output logic [NUM_BITS-1:0]            mul_a,
  output logic [NUM_BITS-1:0]            mul_b,
  output logic [NUM_BITS-1:0]            mul_c,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
  input  logic                           mul_ov
);

  localparam int PROD_W = NUM_INPUTS * NUM_BITS;
  // Wide enough to hold CLR_CYC-1 even when CLR_CYC is 1.
  localparam int CLR_W  = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYC - 1);
  localparam logic [CYC_W-1:0] TIMEOUT_V = CYC_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CLR_W-1:0] clr_cnt;
  logic [CYC_W-1:0] cyc_cnt;

  // Handshake and run-termination events, all qualified by the registered state.
  logic             accept;
  logic [CYC_W-1:0] cnt_next;
  logic             run_to;
  logic             finish;
  logic             handoff;

  assign accept   = (state == S_IDLE) && in_valid;
  assign cnt_next = cyc_cnt + CYC_W'(1);
  // A timeout is only declared when ov is absent, so ov wins a tie.
  assign run_to   = (state == S_RUN) && !mul_ov && (cnt_next == TIMEOUT_V);
  assign finish   = (state == S_RUN) && (mul_ov || (cnt_next == TIMEOUT_V));
  assign handoff  = (state == S_DONE) && out_ready;

  // Control FSM: state, counters and every handshake/multiplier control pin,
  // each registered together with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mul_rst   <= 1'b1;
      mul_en    <= 1'b0;
      clr_cnt   <= '0;
      cyc_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_CLEAR;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            clr_cnt  <= '0;
            cyc_cnt  <= '0;
          end
        end
        S_CLEAR: begin
          // Multiplier reset stays asserted for exactly CLR_CYC cycles.
          if (clr_cnt == CLR_LAST) begin
            state   <= S_RUN;
            mul_rst <= 1'b0;
            mul_en  <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        S_RUN: begin
          cyc_cnt <= cnt_next;
          if (finish) begin
            state     <= S_DONE;
            mul_en    <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Multiplier stays released but frozen so its state can be inspected.
          if (handoff) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            mul_rst   <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          mul_rst   <= 1'b1;
          mul_en    <= 1'b0;
        end
      endcase
    end
  end

  // Operand latch at accept and result capture at the end of a run; the result
  // fields then hold until the next run finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a       <= '0;
      mul_b       <= '0;
      mul_c       <= '0;
      out_z       <= '0;
      out_cycles  <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
        mul_c <= in_c;
      end
      if (finish) begin
        out_z       <= mul_z;
        out_cycles  <= mul_ov ? cnt_next : TIMEOUT_V;
        out_timeout <= run_to;
      end
    end
  end

`ifdef DSC_MUL_CTRL_CHECK_EN

  logic [PROD_W-1:0] exact_q;

  // Exact product of the three operands at full product width.
  function automatic logic [PROD_W-1:0] exact_prod(
    input logic [NUM_BITS-1:0] a,
    input logic [NUM_BITS-1:0] b,
    input logic [NUM_BITS-1:0] c
  );
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;
    logic [PROD_W-1:0] ec;
    ea = PROD_W'(a);
    eb = PROD_W'(b);
    ec = PROD_W'(c);
    return ea * eb * ec;
  endfunction

  // Reference product is registered at accept; the mismatch flag is decided
  // when the result is captured and held with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exact_q      <= '0;
      out_mismatch <= 1'b0;
    end else begin
      if (accept) begin
        exact_q <= exact_prod(in_a, in_b, in_c);
      end
      if (finish) begin
        out_mismatch <= run_to || (mul_z != exact_q);
      end
    end
  end

`else

  assign out_mismatch = 1'b0;

`endif

endmodule
